uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit UART transmitter. One start bit (0), eight data bits sent
//            LSB first, an optional even-parity bit and one stop bit (1).
//            Every bit is held for CLKS_PER_BIT clock cycles.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous active-high reset
//            tx_data  - byte to send, sampled only when a start is accepted
//            tx_start - request to send tx_data
//            tx_ready - high while idle, i.e. when tx_start will be accepted
//            tx_done  - one-cycle pulse on the first idle cycle after a frame
//            tx       - registered serial line, idles high
// Config   : define UART_TX_PARITY_EN to insert an even-parity bit after the
//            data bits (frame becomes 11 bit times instead of 10).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);

    // Counter is just wide enough to hold CLKS_PER_BIT-1.
    localparam int                    c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0]   c_BAUD_ONE  = c_BAUD_W'(1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_S_STOP   = 3'd4;

    logic [2:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_done;

    logic [2:0]          w_state_nxt;
    logic [c_BAUD_W-1:0] w_baud_nxt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_bit_end;
    logic                w_tx_nxt;
    logic                w_done_nxt;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at acceptance, since the shift register
    // no longer holds it by the time the parity bit goes out.
    logic                r_parity;
    logic                w_parity_nxt;
`endif

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    // ------------------------------------------------------------------
    // State register (also holds the datapath and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        // Counter restarts at every bit boundary, otherwise counts up.
        w_baud_nxt   = w_bit_end ? '0 : (r_baud_cnt + c_BAUD_ONE);
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            c_S_IDLE: begin
                w_baud_nxt = '0;
                if (tx_start) begin
                    w_state_nxt  = c_S_START;
                    w_bit_nxt    = '0;
                    w_shift_nxt  = tx_data;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^tx_data;
`endif
                end
            end
            c_S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = c_S_DATA;
                end
            end
            c_S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = c_S_PARITY;
`else
                        w_state_nxt = c_S_STOP;
`endif
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = c_S_STOP;
                end
            end
`endif
            c_S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so tx can be a flop that
    // changes on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            c_S_START:  w_tx_nxt = 1'b0;
            c_S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:    w_tx_nxt = 1'b1;
        endcase
        w_done_nxt = (r_state == c_S_STOP) && w_bit_end;
    end

    // Ready includes the tx_done cycle, so back-to-back frames need no gap.
    assign tx_ready = (r_state == c_S_IDLE);
    assign tx_done  = r_done;
    assign tx       = r_tx;

endmodule
`default_nettype wire
